// File: rtl/move_pkg.sv
// Shared move-command encodings and FSM types for the player move counter path.
// MOV_* codes are consumed by the counter; never let an idle path produce MOV_L.
package move_pkg;

  localparam logic [1:0] MOV_L    = 2'b00;
  localparam logic [1:0] MOV_R    = 2'b01;
  localparam logic [1:0] MOV_HOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE_L = 2'd1,
    ST_MOVE_R = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_e;

  // Exactly one button pressed selects a direction; both or neither cancel out.
  function automatic dir_e resolve_dir(input logic left, input logic right);
    if (left && !right) return DIR_LEFT;
    if (right && !left) return DIR_RIGHT;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw push-button.
// The output only follows the synced input after DEBOUNCE_CYCLES consecutive differing cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic btn_o
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = sync2_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_o = deb_q;

endmodule

// File: rtl/move_ctrl_gen.sv
// Turns debounced left/right buttons into paced, edge-clamped move pulses for the counter.
// ctrl idles at MOV_HOLD; a pulse is one cycle of MOV_L/MOV_R every STEP_PERIOD cycles.
module move_ctrl_gen
  import move_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned STEP_PERIOD     = 100000,
  parameter int unsigned POS_W           = 10,
  parameter int unsigned POS_MIN         = 0,
  parameter int unsigned POS_MAX         = 639
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             enable,
  input  logic [POS_W-1:0] pos,
  output logic [1:0]       ctrl,
  output logic             moving
);

  localparam int unsigned       PACE_W    = $clog2(STEP_PERIOD);
  localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(STEP_PERIOD - 1);
  localparam logic [POS_W-1:0]  POS_MIN_C = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0]  POS_MAX_C = POS_W'(POS_MAX);

  logic              left_deb, right_deb;
  dir_e              dir;
  state_e            state_q, state_d;
  logic [PACE_W-1:0] pace_q, pace_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              moving_q, moving_d;
  logic              pulse_due;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk   (clk),
    .reset (reset),
    .btn_i (btn_left),
    .btn_o (left_deb)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk   (clk),
    .reset (reset),
    .btn_i (btn_right),
    .btn_o (right_deb)
  );

  assign dir = resolve_dir(left_deb, right_deb);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pace_q   <= '0;
      ctrl_q   <= MOV_HOLD;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pace_q   <= pace_d;
      ctrl_q   <= ctrl_d;
      moving_q <= moving_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && dir == DIR_LEFT)       state_d = ST_MOVE_L;
        else if (enable && dir == DIR_RIGHT) state_d = ST_MOVE_R;
      end
      ST_MOVE_L: begin
        if (!enable || dir == DIR_NONE) state_d = ST_IDLE;
        else if (dir == DIR_RIGHT)      state_d = ST_MOVE_R;
      end
      ST_MOVE_R: begin
        if (!enable || dir == DIR_NONE) state_d = ST_IDLE;
        else if (dir == DIR_LEFT)       state_d = ST_MOVE_L;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pulse is only issued if the move continues, so leaving MOVE never leaks a partial pulse.
  always_comb begin
    pulse_due = (state_q != ST_IDLE) && (state_d == state_q) && (pace_q == '0);

    pace_d = '0;
    if (state_d == state_q && state_q != ST_IDLE && pace_q != PACE_LAST)
      pace_d = pace_q + 1'b1;

    ctrl_d = MOV_HOLD;
    if (pulse_due) begin
      if (state_q == ST_MOVE_L && pos > POS_MIN_C) ctrl_d = MOV_L;
      if (state_q == ST_MOVE_R && pos < POS_MAX_C) ctrl_d = MOV_R;
    end

    moving_d = (state_d != ST_IDLE);
  end

  assign ctrl   = ctrl_q;
  assign moving = moving_q;

endmodule

// File: tb/tb_move_ctrl_gen.sv
// Randomised self-checking bench for move_ctrl_gen against a cycle-level behavioural model.
// The model tracks button runs, a signed move mode and the age of the current move.
module tb_move_ctrl_gen;

  localparam int D       = 4;
  localparam int S       = 8;
  localparam int POS_W   = 10;
  localparam int POS_MIN = 0;
  localparam int POS_MAX = 639;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             btn_left = 1'b0;
  logic             btn_right = 1'b0;
  logic             enable = 1'b1;
  logic [POS_W-1:0] pos = 10'd319;
  logic [1:0]       ctrl;
  logic             moving;

  int checks = 0;
  int errors = 0;

  // Behavioural model: index 0 = left, 1 = right; mode -1 left, 0 idle, +1 right.
  int         m_s1[2];
  int         m_s2[2];
  int         m_deb[2];
  int         m_run[2];
  int         m_mode = 0;
  int         m_age = 0;
  logic [1:0] m_ctrl = 2'b11;
  logic       m_moving = 1'b0;

  move_ctrl_gen #(
    .DEBOUNCE_CYCLES(D),
    .STEP_PERIOD    (S),
    .POS_W          (POS_W),
    .POS_MIN        (POS_MIN),
    .POS_MAX        (POS_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .enable    (enable),
    .pos       (pos),
    .ctrl      (ctrl),
    .moving    (moving)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic void model_edge();
    int raw[2];
    int req;
    int nmode;
    logic [1:0] nctrl;
    raw[0] = int'(btn_left);
    raw[1] = int'(btn_right);
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_run[b] = 0;
      end
      m_mode = 0; m_age = 0; m_ctrl = 2'b11; m_moving = 1'b0;
      return;
    end
    if (m_deb[0] == 1 && m_deb[1] == 0)      req = -1;
    else if (m_deb[1] == 1 && m_deb[0] == 0) req = 1;
    else                                     req = 0;
    nmode = enable ? req : 0;
    nctrl = 2'b11;
    if (m_mode != 0 && nmode == m_mode && (m_age % S) == 0) begin
      if (m_mode < 0 && int'(pos) > POS_MIN) nctrl = 2'b00;
      if (m_mode > 0 && int'(pos) < POS_MAX) nctrl = 2'b01;
    end
    if (nmode != m_mode)  m_age = 0;
    else if (m_mode != 0) m_age = m_age + 1;
    else                  m_age = 0;
    m_mode   = nmode;
    m_ctrl   = nctrl;
    m_moving = (nmode != 0);
    for (int b = 0; b < 2; b++) begin
      if (m_s2[b] != m_deb[b]) begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] == D) begin
          m_deb[b] = m_s2[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endfunction

  // Advance one clock: model follows the edge, outputs are then stable at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_left = 1'b0; btn_right = 1'b0; enable = 1'b1; pos = 10'd319;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ctrl !== 2'b11 || moving !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: ctrl=%b moving=%b expected ctrl=11 moving=0", i, ctrl, moving);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_hold_left();
    int first;
    int last;
    first = -1; last = -1;
    pos = 10'd319; enable = 1'b1; btn_left = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ctrl !== m_ctrl || moving !== m_moving) begin
        errors++;
        $display("FAIL hold_left cyc %0d: ctrl=%b moving=%b expected ctrl=%b moving=%b", i, ctrl, moving, m_ctrl, m_moving);
      end
      checks++;
      if (ctrl === 2'b00) begin
        if (first < 0) first = i;
        if (last >= 0) begin
          if (i - last !== S) begin
            errors++;
            $display("FAIL hold_left_spacing: got %0d cycles expected %0d", i - last, S);
          end
          checks++;
        end
        last = i;
      end
    end
    if (first !== D + 4) begin
      errors++;
      $display("FAIL hold_left_latency: first pulse at cycle %0d expected %0d", first, D + 4);
    end
    checks++;
    btn_left = 1'b0;
    settle(12);
  endtask

  task automatic test_glitch();
    btn_right = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 3) btn_right = 1'b0;
      tick();
      if (ctrl === 2'b01 || moving !== 1'b0 || ctrl !== m_ctrl) begin
        errors++;
        $display("FAIL glitch cyc %0d: ctrl=%b moving=%b expected ctrl=%b moving=0", i, ctrl, moving, m_ctrl);
      end
      checks++;
    end
  endtask

  task automatic test_both();
    int rise;
    int pulse;
    rise = -1; pulse = -1;
    btn_left = 1'b1; btn_right = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ctrl !== 2'b11 || moving !== 1'b0) begin
        errors++;
        $display("FAIL both_hold cyc %0d: ctrl=%b moving=%b expected ctrl=11 moving=0", i, ctrl, moving);
      end
      checks++;
    end
    btn_right = 1'b0;
    for (int i = 0; i < 20 && pulse < 0; i++) begin
      tick();
      if (ctrl !== m_ctrl || moving !== m_moving) begin
        errors++;
        $display("FAIL both_release cyc %0d: ctrl=%b moving=%b expected ctrl=%b moving=%b", i, ctrl, moving, m_ctrl, m_moving);
      end
      checks++;
      if (moving === 1'b1 && rise < 0) rise = i;
      if (ctrl === 2'b00) pulse = i;
    end
    if (rise < 0 || pulse !== rise + 1) begin
      errors++;
      $display("FAIL both_immediate: moving rose at %0d, first left pulse at %0d, expected one cycle later", rise, pulse);
    end
    checks++;
    btn_left = 1'b0;
    settle(12);
  endtask

  task automatic test_clamp(input logic go_right);
    int  seen;
    int  wait_n;
    logic [1:0] code;
    code = go_right ? 2'b01 : 2'b00;
    pos = go_right ? 10'(POS_MAX) : 10'(POS_MIN);
    btn_left = !go_right; btn_right = go_right;
    wait_n = int'($urandom_range(20, 36));
    for (int i = 0; i < wait_n; i++) begin
      tick();
      if (ctrl === code || ctrl !== m_ctrl || moving !== m_moving) begin
        errors++;
        $display("FAIL clamp_edge dir=%0d cyc %0d: ctrl=%b moving=%b expected ctrl=%b moving=%b", go_right, i, ctrl, moving, m_ctrl, m_moving);
      end
      checks++;
    end
    pos = go_right ? 10'(POS_MAX - 1) : 10'(POS_MIN + 1);
    seen = 0;
    for (int i = 0; i < S + 2 && seen == 0; i++) begin
      tick();
      if (ctrl !== m_ctrl || moving !== m_moving) begin
        errors++;
        $display("FAIL clamp_resume dir=%0d cyc %0d: ctrl=%b moving=%b expected ctrl=%b moving=%b", go_right, i, ctrl, moving, m_ctrl, m_moving);
      end
      checks++;
      if (ctrl === code) seen = 1;
    end
    if (seen == 0) begin
      errors++;
      $display("FAIL clamp_resume_timeout dir=%0d: no pulse within %0d cycles", go_right, S + 2);
    end
    checks++;
    btn_left = 1'b0; btn_right = 1'b0; pos = 10'd319;
    settle(12);
  endtask

  task automatic test_enable_reset();
    int got;
    pos = 10'd319; enable = 1'b1; btn_left = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      if (moving === 1'b1) got = 1;
    end
    settle(int'($urandom_range(1, 5)));
    enable = 1'b0;
    tick();
    if (got == 0 || ctrl !== 2'b11 || moving !== 1'b0 || ctrl !== m_ctrl) begin
      errors++;
      $display("FAIL enable_drop: ctrl=%b moving=%b expected ctrl=11 moving=0 (moved=%0d)", ctrl, moving, got);
    end
    checks++;
    enable = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && got == 0; i++) begin
      tick();
      if (ctrl === 2'b00) got = 1;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (got == 0 || ctrl !== 2'b11 || moving !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pulse: ctrl=%b moving=%b expected ctrl=11 moving=0 (pulse seen=%0d)", ctrl, moving, got);
    end
    checks++;
    btn_left = 1'b0;
    settle(12);
  endtask

  task automatic test_random();
    int pos_set[5];
    pos_set[0] = 0; pos_set[1] = 1; pos_set[2] = 319; pos_set[3] = 638; pos_set[4] = 639;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        btn_left  = 1'($urandom_range(0, 1));
        btn_right = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 24) == 0) pos = 10'(pos_set[$urandom_range(0, 4)]);
      reset = ($urandom_range(0, 149) == 0);
      tick();
      if (ctrl !== m_ctrl || moving !== m_moving) begin
        errors++;
        $display("FAIL random cyc %0d: ctrl=%b moving=%b expected ctrl=%b moving=%b", i, ctrl, moving, m_ctrl, m_moving);
      end
      checks++;
    end
    reset = 1'b0; enable = 1'b1; btn_left = 1'b0; btn_right = 1'b0;
    settle(12);
  endtask

  initial begin
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_run[b] = 0;
    end
    @(negedge clk);
    test_reset();
    test_hold_left();
    test_glitch();
    test_both();
    test_clamp(1'b1);
    test_clamp(1'b0);
    test_enable_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
